// File: rtl/imm_encoder.sv
// imm_encoder: packs an opcode, register fields and a 32-bit immediate into an
// RV32 instruction word. This is the inverse of the core's immediate generator.
// It also flags immediates that the target format cannot represent.
// Two-stage valid/ready pipeline with saturating statistics counters.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm
//                       request fields; in_imm is in sign-extended form
//   out_valid/out_ready result handshake
//   out_instr, out_err  encoded word; error code
//                       0 ok, 1 range, 2 alignment, 3 unsupported opcode
//   enc_count           output handshakes, saturating
//   err_count           output handshakes with out_err != 0, saturating
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {FMT_U, FMT_I, FMT_S, FMT_J, FMT_X} fmt_e;

    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_imm;
    logic        s2_valid;
    logic        s2_load;

    fmt_e        fmt;
    logic [31:0] enc_instr;
    logic [1:0]  enc_err;
    logic        fits12;
    logic        fits21;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // Stage 1: register request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_imm    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_imm    <= in_imm;
            end
        end
    end

    always_comb begin
        fmt = FMT_X;
        case (s1_opcode)
            7'b0010111, 7'b0110111:             fmt = FMT_U;
            7'b1100111, 7'b0000011, 7'b0010011: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1101111:                         fmt = FMT_J;
            default:                            fmt = FMT_X;
        endcase
    end

    // A value fits a signed N-bit field when every bit above bit N-2 matches
    // the sign bit.
    assign fits12 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign fits21 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

    always_comb begin
        enc_instr = '0;
        enc_err   = 2'd0;
        case (fmt)
            FMT_U: begin
                enc_instr = {s1_imm[31:12], s1_rd, s1_opcode};
                enc_err   = (s1_imm[11:0] != 12'd0) ? 2'd2 : 2'd0;
            end
            FMT_I: begin
                enc_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                enc_err   = fits12 ? 2'd0 : 2'd1;
            end
            FMT_S: begin
                enc_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:0], s1_opcode};
                enc_err   = fits12 ? 2'd0 : 2'd1;
            end
            FMT_J: begin
                enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                             s1_imm[19:12], s1_rd, s1_opcode};
                // Alignment is reported ahead of range
                if (s1_imm[0])    enc_err = 2'd2;
                else if (!fits21) enc_err = 2'd1;
                else              enc_err = 2'd0;
            end
            default: begin
                enc_instr = {7'b0, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
                enc_err   = 2'd3;
            end
        endcase
    end

    // Stage 2: register encoded word; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_instr <= '0;
            out_err   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= enc_instr;
                out_err   <= enc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            if (enc_count != '1) enc_count <= enc_count + 1'b1;
            if (out_err != 2'd0 && err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule
